// File: rtl/branch_resolver.sv
// branch_resolver: in-order queue of fetch predictions checked against execute outcomes; BRES_STATS_EN adds resolve/mispredict counters.
// Latency: redirect and BTB write registered one cycle after resolve; backpressure via fetch_ready (low when full or draining).
module branch_resolver #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  input  logic [15:0] fetch_PC,
  input  logic [15:0] fetch_NPC_pred,
  output logic        fetch_ready,
  input  logic        res_valid,
  input  logic [15:0] res_PC,
  input  logic [15:0] res_NPC_actual,
  output logic        redirect_valid,
  output logic [15:0] redirect_PC,
  output logic        btb_we,
  output logic [15:0] btb_PC_actual,
  output logic [15:0] btb_NPC_actual,
  output logic        protocol_err
`ifdef BRES_STATS_EN
  , output logic [15:0] stat_resolved
  , output logic [15:0] stat_mispredict
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [13:0]   q_pc  [DEPTH];
  logic [13:0]   q_npc [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          resolve;
  logic          mispredict;
  logic          pc_err;
  logic          empty_err;

  // PCs are word aligned, so the two low bits never carry information.
  logic unused_lsbs;
  assign unused_lsbs = ^{fetch_PC[1:0], fetch_NPC_pred[1:0]};

  always_comb begin
    state_nxt   = state;
    fetch_ready = 1'b0;
    push        = 1'b0;
    resolve     = 1'b0;
    mispredict  = 1'b0;
    pc_err      = 1'b0;
    empty_err   = 1'b0;
    if (state == RUN) begin
      fetch_ready = (count < CNT_FULL);
      push        = fetch_valid && fetch_ready;
      if (res_valid) begin
        if (count != '0) begin
          resolve    = 1'b1;
          mispredict = (q_npc[rd_ptr] != res_NPC_actual[15:2]);
          pc_err     = (q_pc[rd_ptr] != res_PC[15:2]);
        end else begin
          empty_err = 1'b1;
        end
      end
      if (mispredict) begin
        state_nxt = DRAIN;
      end
    end else begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]  <= fetch_PC[15:2];
      q_npc[wr_ptr] <= fetch_NPC_pred[15:2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= RUN;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      redirect_valid <= 1'b0;
      redirect_PC    <= '0;
      btb_we         <= 1'b0;
      btb_PC_actual  <= '0;
      btb_NPC_actual <= '0;
      protocol_err   <= 1'b0;
    end else begin
      state          <= state_nxt;
      redirect_valid <= mispredict;
      btb_we         <= mispredict;
      if (pc_err || empty_err) begin
        protocol_err <= 1'b1;
      end
      if (mispredict) begin
        redirect_PC    <= res_NPC_actual;
        btb_PC_actual  <= res_PC;
        btb_NPC_actual <= res_NPC_actual;
        // Everything younger than the mispredicted entry is wrong-path,
        // including a fetch offered in this same cycle.
        rd_ptr         <= '0;
        wr_ptr         <= '0;
        count          <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (resolve) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        case ({push, resolve})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

`ifdef BRES_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_resolved   <= '0;
      stat_mispredict <= '0;
    end else begin
      if (resolve && (stat_resolved != 16'hFFFF)) begin
        stat_resolved <= stat_resolved + 16'd1;
      end
      if (mispredict && (stat_mispredict != 16'hFFFF)) begin
        stat_mispredict <= stat_mispredict + 16'd1;
      end
    end
  end
`endif

endmodule
